// File: rtl/servo_pwm_multi.sv
// N-channel servo pulse generator: per-channel width targets in microseconds, clamped,
// slewed once per frame, frame-latched enables; active widths readable through a registered port.
module servo_pwm_multi #(
   parameter int  NUM_CH    = 2,
   parameter int  CLK_DIV   = 100,
   parameter int  FRAME_US  = 20000,
   parameter int  MIN_US    = 1000,
   parameter int  MAX_US    = 2000,
   parameter int  CENTER_US = 1500,
   parameter int  SLEW_US   = 10,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              FAB_CLK,
   input  logic              FAB_RESET,
   input  logic              WR_EN,
   input  logic [CH_W-1:0]   WR_CH,
   input  logic [15:0]       WR_DATA,
   input  logic [NUM_CH-1:0] CH_ENABLE,
   input  logic [CH_W-1:0]   RD_CH,
   output logic [15:0]       RD_DATA,
   output logic [NUM_CH-1:0] PWM_OUT,
   output logic              FRAME_STROBE
);

   localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int            CHW1       = CH_W + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [15:0]   FRAME_LAST = 16'(FRAME_US - 1);
   localparam logic [15:0]   MIN_W      = 16'(MIN_US);
   localparam logic [15:0]   MAX_W      = 16'(MAX_US);
   localparam logic [15:0]   CENTER_W   = 16'(CENTER_US);
   localparam logic [15:0]   SLEW_W     = 16'(SLEW_US);
   localparam logic [CH_W:0] NUM_CH_W   = CHW1'(NUM_CH);

   logic [PW-1:0]     presc_q, presc_d;
   logic [15:0]       frame_q, frame_d;
   logic [15:0]       target_q [NUM_CH];
   logic [15:0]       target_d [NUM_CH];
   logic [15:0]       active_q [NUM_CH];
   logic [15:0]       active_d [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              strobe_q, strobe_d;
   logic [15:0]       rd_q, rd_d;
   logic              tick, boundary;
   logic              wr_valid, rd_valid;
   logic [15:0]       wr_clamped;

   // One frame's step of the active width toward its target; never overshoots.
   function automatic logic [15:0] slew_step(input logic [15:0] cur, input logic [15:0] tgt);
      logic [15:0] res;
      res = tgt;
      if (SLEW_US != 0) begin
         if ((tgt > cur) && ((tgt - cur) > SLEW_W)) begin
            res = cur + SLEW_W;
         end else if ((cur > tgt) && ((cur - tgt) > SLEW_W)) begin
            res = cur - SLEW_W;
         end
      end
      return res;
   endfunction

   always_comb begin
      tick     = (presc_q == PRESC_LAST);
      boundary = tick && (frame_q == FRAME_LAST);
      presc_d  = tick ? '0 : presc_q + PW'(1);
      frame_d  = frame_q;
      if (tick) begin
         frame_d = boundary ? 16'd0 : frame_q + 16'd1;
      end
      strobe_d = boundary;

      // WR_EN is a fire-and-forget valid: there is no ready, every strobe is accepted.
      wr_clamped = WR_DATA;
      if (WR_DATA < MIN_W) begin
         wr_clamped = MIN_W;
      end else if (WR_DATA > MAX_W) begin
         wr_clamped = MAX_W;
      end
      wr_valid = WR_EN && ({1'b0, WR_CH} < NUM_CH_W);
      rd_valid = ({1'b0, RD_CH} < NUM_CH_W);

      en_d  = en_q;
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         target_d[i] = target_q[i];
         if (wr_valid && (WR_CH == CH_W'(i))) begin
            target_d[i] = wr_clamped;
         end
         // The boundary sees only targets registered before it; a same-cycle write waits a frame.
         active_d[i] = active_q[i];
         if (boundary) begin
            active_d[i] = slew_step(active_q[i], target_q[i]);
            en_d[i]     = CH_ENABLE[i];
         end
         pwm_d[i] = en_d[i] && (frame_d < active_d[i]);
      end

      rd_d = '0;
      if (rd_valid) begin
         rd_d = active_q[RD_CH];
      end
   end

   always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
      if (FAB_RESET) begin
         presc_q  <= '0;
         frame_q  <= '0;
         en_q     <= '0;
         pwm_q    <= '0;
         strobe_q <= 1'b0;
         rd_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= CENTER_W;
            active_q[i] <= CENTER_W;
         end
      end else begin
         presc_q  <= presc_d;
         frame_q  <= frame_d;
         en_q     <= en_d;
         pwm_q    <= pwm_d;
         strobe_q <= strobe_d;
         rd_q     <= rd_d;
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= target_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign RD_DATA      = rd_q;
   assign PWM_OUT      = pwm_q;
   assign FRAME_STROBE = strobe_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a slewing 3-channel instance and an immediate 2-channel instance
// checked cycle by cycle against a frame-level reference model through an expected-value queue.
module tb_servo_pwm_multi;

   localparam int CLK_DIV   = 2;
   localparam int FRAME_US  = 100;
   localparam int MIN_US    = 10;
   localparam int MAX_US    = 20;
   localparam int CENTER_US = 15;
   localparam int FRAME_CYC = CLK_DIV * FRAME_US;
   localparam int EW        = 39;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        wr_en0, wr_en1;
   logic [1:0]  wr_ch0;
   logic [0:0]  wr_ch1;
   logic [15:0] wr_data0, wr_data1;
   logic [2:0]  ch_en0;
   logic [1:0]  ch_en1;
   logic [1:0]  rd_ch0;
   logic [0:0]  rd_ch1;
   logic [15:0] rd_data0, rd_data1;
   logic [2:0]  pwm0;
   logic [1:0]  pwm1;
   logic        strobe0, strobe1;

   servo_pwm_multi #(
      .NUM_CH(3), .CLK_DIV(CLK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
      .MAX_US(MAX_US), .CENTER_US(CENTER_US), .SLEW_US(2)
   ) dut0 (
      .FAB_CLK(clk), .FAB_RESET(rst), .WR_EN(wr_en0), .WR_CH(wr_ch0), .WR_DATA(wr_data0),
      .CH_ENABLE(ch_en0), .RD_CH(rd_ch0), .RD_DATA(rd_data0), .PWM_OUT(pwm0),
      .FRAME_STROBE(strobe0)
   );

   servo_pwm_multi #(
      .NUM_CH(2), .CLK_DIV(CLK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
      .MAX_US(MAX_US), .CENTER_US(CENTER_US), .SLEW_US(0)
   ) dut1 (
      .FAB_CLK(clk), .FAB_RESET(rst), .WR_EN(wr_en1), .WR_CH(wr_ch1), .WR_DATA(wr_data1),
      .CH_ENABLE(ch_en1), .RD_CH(rd_ch1), .RD_DATA(rd_data1), .PWM_OUT(pwm1),
      .FRAME_STROBE(strobe1)
   );

   // ---------------- reference model (frame-level) ----------------
   int tgt [2][3];
   int act [2][3];
   bit en  [2][3];
   int rd_m [2];
   int t;
   bit in_rst;

   logic [EW-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic int nch(input int d);
      return (d == 0) ? 3 : 2;
   endfunction

   function automatic int slew_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic int clamp(input int v);
      if (v < MIN_US) return MIN_US;
      if (v > MAX_US) return MAX_US;
      return v;
   endfunction

   function automatic int approach(input int cur, input int goal, input int s);
      if (s == 0) return goal;
      if (goal > cur) return (goal - cur > s) ? cur + s : goal;
      return (cur - goal > s) ? cur - s : goal;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         rd_m[d] = 0;
         for (int c = 0; c < 3; c++) begin
            tgt[d][c] = CENTER_US;
            act[d][c] = CENTER_US;
            en[d][c]  = 1'b0;
         end
      end
   endtask

   // Applies the clock edge that opens cycle t, using the inputs held during cycle t-1.
   task automatic model_edge();
      int we [2];
      int wc [2];
      int wd [2];
      int rc [2];
      logic [2:0] ce [2];
      we[0] = int'(wr_en0); wc[0] = int'(wr_ch0); wd[0] = int'(wr_data0);
      rc[0] = int'(rd_ch0); ce[0] = ch_en0;
      we[1] = int'(wr_en1); wc[1] = int'(wr_ch1); wd[1] = int'(wr_data1);
      rc[1] = int'(rd_ch1); ce[1] = {1'b0, ch_en1};
      for (int d = 0; d < 2; d++) begin
         rd_m[d] = (rc[d] < nch(d)) ? act[d][rc[d]] : 0;
         if ((t > 0) && (t % FRAME_CYC == 0)) begin
            for (int c = 0; c < nch(d); c++) begin
               act[d][c] = approach(act[d][c], tgt[d][c], slew_of(d));
               en[d][c]  = ce[d][c];
            end
         end
         if ((we[d] != 0) && (wc[d] < nch(d))) tgt[d][wc[d]] = clamp(wd[d]);
      end
   endtask

   function automatic logic [EW-1:0] expect_now();
      logic [2:0] p0;
      logic [1:0] p1;
      logic       s;
      int         ph;
      ph = t % FRAME_CYC;
      s  = (t > 0) && (ph == 0);
      for (int c = 0; c < 3; c++) p0[c] = en[0][c] && (ph < act[0][c] * CLK_DIV);
      for (int c = 0; c < 2; c++) p1[c] = en[1][c] && (ph < act[1][c] * CLK_DIV);
      return {16'(rd_m[0]), p0, s, 16'(rd_m[1]), p1, s};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input bit r);
      @(posedge clk);
      #1;
      if (r) begin
         rst    = 1'b1;
         in_rst = 1'b1;
         model_reset();
         exp_q.push_back('0);
      end else if (in_rst) begin
         rst    = 1'b0;
         in_rst = 1'b0;
         t      = 0;
         exp_q.push_back(expect_now());
      end else begin
         t++;
         model_edge();
         exp_q.push_back(expect_now());
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 2 * FRAME_CYC; i++) begin
         if (t % FRAME_CYC == p) break;
         step(1'b0);
      end
   endtask

   task automatic wr(input int d, input int ch, input int data);
      if (d == 0) begin
         wr_en0 = 1'b1; wr_ch0 = 2'(ch); wr_data0 = 16'(data);
      end else begin
         wr_en1 = 1'b1; wr_ch1 = 1'(ch); wr_data1 = 16'(data);
      end
      step(1'b0);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, a, e);
      end
   endtask

   logic [EW-1:0] mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("rd_data0", rd_data0,          mon_e[38:23]);
         check("pwm0",     {13'd0, pwm0},     {13'd0, mon_e[22:20]});
         check("strobe0",  {15'd0, strobe0},  {15'd0, mon_e[19]});
         check("rd_data1", rd_data1,          mon_e[18:3]);
         check("pwm1",     {14'd0, pwm1},     {14'd0, mon_e[2:1]});
         check("strobe1",  {15'd0, strobe1},  {15'd0, mon_e[0]});
      end
   end

   // ---------------- scenarios ----------------
   initial begin
      wr_en0 = 1'b0; wr_ch0 = '0; wr_data0 = '0; ch_en0 = 3'b111; rd_ch0 = '0;
      wr_en1 = 1'b0; wr_ch1 = '0; wr_data1 = '0; ch_en1 = 2'b11;  rd_ch1 = '0;
      t = 0;
      in_rst = 1'b1;
      model_reset();

      // reset, idle frames at the centre width, then a reset in the middle of a pulse
      repeat (3) step(1'b1);
      run(420);
      repeat (4) step(1'b1);
      run(650);

      // clamping and slew toward high and low targets; immediate update on the unslewed unit
      wr(0, 0, 50);
      wr(0, 1, 3);
      wr(1, 0, 18);
      rd_ch0 = 2'd1;
      run(1000);

      // writes in the wrap cycle and in the strobe cycle are both deferred a frame
      rd_ch0 = 2'd0;
      wait_phase(FRAME_CYC - 1);
      wr(1, 1, 12);
      wr(0, 0, 11);
      run(600);

      // enable dropped mid-pulse, then re-enabled mid-frame
      wait_phase(10);
      ch_en0[1] = 1'b0;
      ch_en1[1] = 1'b0;
      run(5);
      wait_phase(0);
      wait_phase(50);
      ch_en0[1] = 1'b1;
      ch_en1[1] = 1'b1;
      run(500);

      // out-of-range write and readback index
      wr(0, 3, 12);
      rd_ch0 = 2'd3;
      run(5);
      rd_ch0 = 2'd2;
      run(400);

      // randomized mix of writes, enables, readback selects and resets
      for (int i = 0; i < 40; i++) begin
         run($urandom_range(1, 120));
         case ($urandom_range(0, 4))
            0: wr(0, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 30));
            1: wr(1, $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 30));
            2: begin
               ch_en0 = 3'($urandom_range(0, 7));
               ch_en1 = 2'($urandom_range(0, 3));
            end
            3: begin
               rd_ch0 = 2'($urandom_range(0, 3));
               rd_ch1 = 1'($urandom_range(0, 1));
            end
            default: repeat (2) step(1'b1);
         endcase
      end
      run(400);

      @(negedge clk);
      #1;
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
